// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage
// and the multicycle controller that drives it.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_SEL_SEQ  = 3'b000,
        PC_SEL_BR   = 3'b001,
        PC_SEL_JALR = 3'b010,
        PC_SEL_JAL  = 3'b100
    } pc_sel_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/next_pc_gen.sv
// Combinational next-PC target selection and alignment check.
// Unlisted pc_sel encodings fall back to sequential fetch.
module next_pc_gen
    import fetch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [2:0]      pc_sel,
    input  logic [XLEN-1:0] br_imm,
    input  logic [XLEN-1:0] jal_imm,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_sum;

    assign jalr_sum = rs1_data + i_imm;

    always_comb begin
        target = pc + XLEN'(4);
        case (pc_sel)
            PC_SEL_BR:   target = pc + br_imm;
            PC_SEL_JALR: target = {jalr_sum[XLEN-1:1], 1'b0};
            PC_SEL_JAL:  target = pc + jal_imm;
            default:     target = pc + XLEN'(4);
        endcase
    end

    assign misaligned = |target[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register, sticky
// misalignment flag and retired-instruction counter.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter int          IMEM_AW  = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetch_instr,
    input  logic               update_pc,
    input  logic [2:0]         pc_sel,
    input  logic [XLEN-1:0]    br_imm,
    input  logic [XLEN-1:0]    jal_imm,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [XLEN-1:0]    rs1_data,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [XLEN-1:0]    imem_rdata,
    output logic [XLEN-1:0]    instr,
    output logic [6:0]         opcode,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    pc_plus4,
    output logic               instr_valid,
    output logic               misalign_err,
    output logic [CNT_W-1:0]   instret
);

    logic [XLEN-1:0] target;
    logic            misaligned;

    next_pc_gen #(
        .XLEN(XLEN)
    ) u_next_pc (
        .pc        (pc),
        .pc_sel    (pc_sel),
        .br_imm    (br_imm),
        .jal_imm   (jal_imm),
        .i_imm     (i_imm),
        .rs1_data  (rs1_data),
        .target    (target),
        .misaligned(misaligned)
    );

    assign imem_addr = pc[IMEM_AW+1:2];
    assign opcode    = instr[6:0];
    assign pc_plus4  = pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= XLEN'(RESET_PC);
            instr        <= XLEN'(NOP_INSTR);
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            instret      <= '0;
        end else begin
            if (fetch_instr) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            // A committed PC change wins over a same-cycle fetch on instr_valid.
            if (update_pc && !misalign_err) begin
                if (misaligned) begin
                    misalign_err <= 1'b1;
                end else begin
                    pc          <= target;
                    instret     <= instret + CNT_W'(1);
                    instr_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the multicycle controller.
- Holds the architectural PC and drives the instruction-memory word address.
- Captures the fetched instruction on the controller's fetch strobe and supplies the opcode back to the controller.
- Computes and commits the next PC on the controller's update strobe, according to the controller's 3-bit PC select; also keeps a sticky misaligned-target flag and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath/PC width.
- IMEM_AW, 10, instruction-memory word-address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 32, instret counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fetch_instr  in  1  controller strobe: latch imem_rdata into instruction register
- update_pc  in  1  controller strobe: commit next PC, retire instruction
- pc_sel  in  3  000 seq, 001 branch, 010 JALR, 100 JAL
- br_imm  in  XLEN  sign-extended B-type offset
- jal_imm  in  XLEN  sign-extended J-type offset
- i_imm  in  XLEN  sign-extended I-type offset (JALR)
- rs1_data  in  XLEN  JALR base register
- imem_addr  out  IMEM_AW  word address = pc[IMEM_AW+1:2]
- imem_rdata  in  XLEN  instruction-memory read data, valid 2 cycles after imem_addr changes
- instr  out  XLEN  instruction register
- opcode  out  7  instr[6:0]
- pc  out  XLEN  current PC (AUIPC base)
- pc_plus4  out  XLEN  pc+4 (JAL/JALR link value)
- instr_valid  out  1  instruction register holds the instruction at pc
- misalign_err  out  1  sticky: a control-transfer target was not word-aligned
- instret  out  CNT_W  retired-instruction count

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-high on reset; all state is updated only on posedge clk.
- Reset values: pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0, misalign_err=0, instret=0. A reset asserted mid-sequence overrides both strobes in that cycle.
- imem_addr, opcode, pc_plus4: combinational from registers; no added latency.
- fetch_instr=1: instr <= imem_rdata, instr_valid <= 1 (next edge).
- Next-PC target by pc_sel:
  - 000: pc+4
  - 001: pc+br_imm
  - 010: (rs1_data+i_imm) & ~1
  - 100: pc+jal_imm
  - 011, 101, 110, 111: treated as 000
- Target arithmetic is modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- update_pc=1 with target[1:0]==0 and misalign_err==0, at the next edge:
  - pc <= target
  - instret <= instret+1, wrapping modulo 2^CNT_W
  - instr_valid <= 0
  - instr is held, so opcode stays stable.
- update_pc=1 with target[1:0]!=0: pc, instret and instr_valid are unchanged; misalign_err <= 1.
- While misalign_err=1, update_pc is ignored (PC frozen). fetch_instr still reloads instr at the same pc. Only reset clears misalign_err.
- Both strobes in the same cycle (the controller never does this; still defined):
  - instr loads from the old address.
  - pc updates, using the old instr-derived inputs.
  - instr_valid ends at 0.
- update_pc with instr_valid=0: permitted; PC updates as normal.
- Latency:
  - fetch_instr to instr visible: 1 cycle.
  - update_pc to new imem_addr: 1 cycle.
  - imem_rdata is assumed valid 2 cycles later, which the controller's two wait states cover.

Decomposition:
- Package fetch_pkg:
  - pc_sel_t enum: PC_SEL_SEQ=3'b000, PC_SEL_BR=3'b001, PC_SEL_JALR=3'b010, PC_SEL_JAL=3'b100.
  - NOP_INSTR=32'h0000_0013.
  - Opcode constants shared with the controller.
- Sub-module next_pc_gen (purely combinational): inputs pc, pc_sel, immediates, rs1_data; outputs target and misaligned.
- fetch_unit holds all registers.

Test Plan:
- Reset with RESET_PC=0x100 -> pc=0x100, imem_addr=0x40, instr=0x00000013, instr_valid=0, instret=0; fetch_instr with imem_rdata=0x00500093 -> instr=0x00500093, opcode=0x13, instr_valid=1.
- Sequential run from pc=0x100: fetch/update pulse pairs repeated 3 times -> pc=0x10C, instret=3, pc_plus4=0x110.
- Branch: pc=0x200, pc_sel=001, br_imm=-8 -> pc=0x1F8. JAL: pc=0x200, pc_sel=100, jal_imm=0x40 -> pc=0x240.
- JALR: rs1_data=0x1001, i_imm=0x3, pc_sel=010 -> pc=0x1004 (bit0 cleared). JALR with rs1_data=0x1002, i_imm=0 -> pc unchanged, misalign_err=1; a further update_pc with pc_sel=000 -> pc still unchanged.
- Wrap: pc=0xFFFF_FFFC, pc_sel=000, update_pc -> pc=0x0000_0000, no error. pc_sel=3'b111 -> behaves as pc+4.
- Reset asserted together with update_pc (pc=0x300) -> pc=RESET_PC, instret=0, misalign_err=0 on the next edge; simultaneous fetch_instr+update_pc -> instr loaded, pc advanced, instr_valid=0.
